// File: rtl/fmap_pkg.sv
// Shared constants, state encoding and sizing helper for the featuremap stream packer.
package fmap_pkg;

  localparam int CH_W           = 32;
  localparam int NUM_CH_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Guarded so a single-entry counter still gets one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmap_word_packer.sv
// Assembles NUM_CH consecutive channel words into one registered packed beat.
module fmap_word_packer
  import fmap_pkg::*;
#(
  parameter int DATA_WIDTH     = CH_W,
  parameter int NUM_CH         = NUM_CH_DEFAULT,
  parameter int DATA_OUT_WIDTH = DATA_WIDTH * NUM_CH
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      clr,
  input  logic                      word_vld,
  input  logic [DATA_WIDTH-1:0]     word,
  output logic                      beat_end,
  output logic [DATA_OUT_WIDTH-1:0] beat,
  output logic                      beat_done
);

  localparam int              CNT_W   = cnt_width(NUM_CH);
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);

  logic [CNT_W-1:0]          ch_cnt;
  logic [DATA_OUT_WIDTH-1:0] asm_p0;
  logic [DATA_OUT_WIDTH-1:0] packed_p0;

  assign beat_end = word_vld && (ch_cnt == LAST_CH);

  // Stage p0: assembly register with the incoming word merged into its slot.
  always_comb begin
    packed_p0 = asm_p0;
    packed_p0[ch_cnt*DATA_WIDTH +: DATA_WIDTH] = word;
  end

  always_ff @(posedge Clk) begin
    if (word_vld) begin
      asm_p0 <= packed_p0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      ch_cnt <= '0;
    end else if (word_vld) begin
      ch_cnt <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + 1'b1;
    end
  end

  // Stage p1: completed beat is registered; it holds between strobes.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      beat      <= '0;
      beat_done <= 1'b0;
    end else begin
      beat_done <= beat_end;
      if (beat_end) begin
        beat <= packed_p0;
      end
    end
  end

endmodule

// File: rtl/fmap_stream_packer.sv
// Frame-level packer: IDLE/RUN control and pixel row/col tracking around fmap_word_packer.
// Optional FMAP_PACKER_ROWEND_EN adds row_end_out, flagging the last beat of each pixel row.
module fmap_stream_packer
  import fmap_pkg::*;
#(
  parameter int DATA_WIDTH     = CH_W,
  parameter int NUM_CH         = NUM_CH_DEFAULT,
  parameter int DATA_OUT_WIDTH = DATA_WIDTH * NUM_CH,
  parameter int IMG_SIZE       = 208
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  output logic                      valid_out,
  output logic                      last_out,
  output logic                      busy,
  output logic                      done
`ifdef FMAP_PACKER_ROWEND_EN
 ,output logic                      row_end_out
`endif
);

  localparam logic [0:0]        ST_IDLE  = IDLE;
  localparam logic [0:0]        ST_RUN   = RUN;
  localparam int                POS_W    = cnt_width(IMG_SIZE);
  localparam logic [POS_W-1:0]  LAST_POS = POS_W'(IMG_SIZE - 1);

  logic [0:0]       state;
  logic [POS_W-1:0] col;
  logic [POS_W-1:0] row;
  logic             accept;
  logic             start_go;
  logic             beat_end;

  assign ready_out = (state == ST_RUN);
  assign busy      = (state == ST_RUN);
  assign accept    = valid_in && ready_out;
  assign start_go  = start && (state == ST_IDLE);

  fmap_word_packer #(
    .DATA_WIDTH     (DATA_WIDTH),
    .NUM_CH         (NUM_CH),
    .DATA_OUT_WIDTH (DATA_OUT_WIDTH)
  ) u_word_packer (
    .Clk       (Clk),
    .Rst       (Rst),
    .clr       (start_go),
    .word_vld  (accept),
    .word      (data_in),
    .beat_end  (beat_end),
    .beat      (data_out),
    .beat_done (valid_out)
  );

  // Stage p1: frame flags register on the same edge as the beat they describe.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= ST_IDLE;
      col      <= '0;
      row      <= '0;
      last_out <= 1'b0;
      done     <= 1'b0;
`ifdef FMAP_PACKER_ROWEND_EN
      row_end_out <= 1'b0;
`endif
    end else begin
      last_out <= 1'b0;
      done     <= 1'b0;
`ifdef FMAP_PACKER_ROWEND_EN
      row_end_out <= beat_end && (col == LAST_POS);
`endif
      if (start_go) begin
        state <= ST_RUN;
        col   <= '0;
        row   <= '0;
      end else if (beat_end) begin
        if (col == LAST_POS) begin
          col <= '0;
          if (row == LAST_POS) begin
            row      <= '0;
            state    <= ST_IDLE;
            last_out <= 1'b1;
            done     <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
